// File: rtl/uart_msg_pkg.sv
// Shared types and default sizes for the UART message sequencer.
package uart_msg_pkg;

  localparam int MSG_MAX_LEN = 16;
  localparam int MSG_DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_LOAD,
    ST_WAITLOAD,
    ST_WAITSEND,
    ST_FINISH
  } msg_state_t;

endpackage

// File: rtl/uart_msg_seq.sv
// Reads a message from a synchronous table and feeds it byte by byte to the
// UART transmitter via ldtxdata/txempty, with repeat, zero-termination and abort.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | table address presented
// CAPTURE  | table byte registered into txdata
// LOAD     | ldtxdata strobe
// WAITLOAD | transmitter takes the byte and drops txempty
// WAITSEND | waiting for txempty, then next byte / repeat / finish
// FINISH   | done pulse, aborted reports the abort flag
module uart_msg_seq
  import uart_msg_pkg::*;
#(
  parameter int MAX_LEN   = MSG_MAX_LEN,
  parameter int ADDR_W    = $clog2(MAX_LEN),
  parameter int DATA_W    = MSG_DATA_W,
  parameter bit ZERO_TERM = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              repeat_en,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              txempty,
  output logic [DATA_W-1:0] txdata,
  output logic              ldtxdata,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = (ADDR_W)'(1);

  msg_state_t        state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   len_q, len_n, len_clamp;
  logic              abort_q, abort_n;
  logic              txdata_ld;
  logic              last_byte;

  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign last_byte = ({1'b0, idx} == (len_q - LEN_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      len_q   <= '0;
      abort_q <= 1'b0;
      txdata  <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      len_q   <= len_n;
      abort_q <= abort_n;
      if (txdata_ld) txdata <= rd_data;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    len_n     = len_q;
    abort_n   = abort_q;
    txdata_ld = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          len_n   = len_clamp;
          idx_n   = '0;
          abort_n = 1'b0;
          state_n = (len_clamp == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        abort_n = abort;
        state_n = abort ? ST_FINISH : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort) begin
          abort_n = 1'b1;
          state_n = ST_FINISH;
        end else if (ZERO_TERM && (rd_data == '0)) begin
          state_n = ST_FINISH;
        end else begin
          txdata_ld = 1'b1;
          state_n   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        abort_n = abort_q | abort;
        state_n = ST_WAITLOAD;
      end
      ST_WAITLOAD: begin
        abort_n = abort_q | abort;
        state_n = ST_WAITSEND;
      end
      ST_WAITSEND: begin
        // an abort arriving together with txempty still counts for this run
        abort_n = abort_q | abort;
        if (txempty) begin
          if (abort_n) begin
            state_n = ST_FINISH;
          end else if (last_byte) begin
            if (repeat_en) begin
              idx_n   = '0;
              state_n = ST_FETCH;
            end else begin
              state_n = ST_FINISH;
            end
          end else begin
            idx_n   = idx + IDX_ONE;
            state_n = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        abort_n = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rd_addr  = idx;
  assign ldtxdata = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FINISH);
  assign aborted  = (state == ST_FINISH) && abort_q;

endmodule
